voice_mixer: RTL and testbench
==============================

VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 Parameter NUM_VOICES, default 3, number of voice channels mixed (legal 1..8).
REQ-002 Parameter SAMPLE_WIDTH, default 16, signed two's-complement sample width.
REQ-003 Parameter MIX_SHIFT, default 2, arithmetic right shift applied to the voice sum.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles spent waiting for voice samples (legal 1..65535).
REQ-005 clk  input  1  system clock; all logic is on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 generate_next_sample  input  1  one-cycle request for one mixed sample (48 kHz pace).
REQ-008 voice_active  input  NUM_VOICES  bit i high means voice i is playing.
REQ-009 sample_in  input  NUM_VOICES*SAMPLE_WIDTH  packed voice samples; voice i occupies bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-010 sample_ready_in  input  NUM_VOICES  one-cycle strobe; voice i sample is valid.
REQ-011 request_sample  output  NUM_VOICES  one-cycle per-voice sample request.
REQ-012 sample_out  output  SAMPLE_WIDTH  mixed sample; held between updates.
REQ-013 sample_ready  output  1  one-cycle strobe; sample_out was updated this cycle.
REQ-014 missed_voices  output  NUM_VOICES  voices that timed out on the last mix; valid with sample_ready.
REQ-015 saturated  output  1  the last mix was clamped; valid with sample_ready.
REQ-016 overrun  output  1  one-cycle strobe; a request arrived while busy.

Function
REQ-017 States: IDLE, COLLECT, MIX, DONE.
REQ-018 IDLE with generate_next_sample: capture pending = voice_active, clear the sample buffer to 0, and go to COLLECT. request_sample = voice_active on the next cycle for exactly one cycle.
REQ-019 COLLECT: sample_ready_in[i] with pending[i] set latches voice i into the buffer and clears pending[i]; simultaneous strobes are all latched in the same cycle.
REQ-020 COLLECT exits to MIX in the cycle after pending reaches 0, or when the wait counter reaches TIMEOUT; pending bits still set at exit become missed_voices, and those voices contribute 0.
REQ-021 pending == 0 at capture means COLLECT lasts exactly one cycle; the mix result is 0.
REQ-022 MIX: sum all buffered samples, each sign-extended to SAMPLE_WIDTH+3 bits, then arithmetic-shift the sum right by MIX_SHIFT, then narrow it to SAMPLE_WIDTH per REQ-030.
REQ-023 DONE: register sample_out, missed_voices and saturated, pulse sample_ready for one cycle, then return to IDLE.
REQ-024 Latency: sample_ready is asserted 2 cycles after the cycle in which the last pending strobe is accepted.
REQ-025 generate_next_sample outside IDLE is dropped and pulses overrun on the next cycle; it produces no extra request_sample.
REQ-026 sample_ready_in in IDLE, MIX or DONE, or for a non-pending voice, is ignored.

Reset
REQ-027 Reset: state = IDLE; sample_out = 0, sample_ready = 0, request_sample = 0, missed_voices = 0, saturated = 0, overrun = 0; buffer, pending and counter all cleared.
REQ-028 Reset mid-COLLECT or mid-MIX aborts the mix with no sample_ready issued.

Configuration
REQ-029 Macro VOICE_MIXER_SATURATE_EN selects clamping; it is absent by default.
REQ-030 Defined: a shifted sum outside the signed SAMPLE_WIDTH range clamps to max or min, and saturated = 1. Undefined: the shifted sum is truncated to its low SAMPLE_WIDTH bits (wrap), and saturated is tied to 0.

Structure
REQ-031 Package voice_mixer_pkg holds the state enum, the guard-bit constant (3), and the counter width constant (16).
REQ-032 Sub-module voice_sum_sat is combinational: it does the sign-extended sum, shift and saturate/wrap, and is instantiated once.

Verification (NUM_VOICES=3, SAMPLE_WIDTH=16)
REQ-033 MIX_SHIFT=1, all voices active, strobes in the same cycle with samples 1000, 2000 and -500 -> sample_out = 1250, one sample_ready 2 cycles later, missed_voices = 0.
REQ-034 MIX_SHIFT=0, three samples of 0x7FFF -> 0x7FFF and saturated=1 with the macro; 0x7FFD and saturated=0 without it.
REQ-035 TIMEOUT=8, voice 2 never strobes, voices 0/1 give 400/400, MIX_SHIFT=0 -> sample_out = 800, missed_voices = 3'b100, sample_ready about 10 cycles after request_sample.
REQ-036 voice_active = 0 with a request -> request_sample stays 0, sample_out = 0, sample_ready issued.
REQ-037 Second generate_next_sample during COLLECT -> overrun pulses once, exactly one sample_ready results.
REQ-038 Reset asserted mid-COLLECT -> no sample_ready, all outputs 0, next request completes normally.

Source files
------------

// File: rtl/voice_mixer_pkg.sv
// voice_mixer_pkg: shared state encoding and sizing constants for the voice mixer.
`default_nettype none

package voice_mixer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_MIX     = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int GUARD_BITS = 3;
   localparam int CNT_WIDTH  = 16;

endpackage

`default_nettype wire

// File: rtl/voice_sum_sat.sv
// voice_sum_sat: combinational sign-extended voice sum, arithmetic shift, then clamp
// (VOICE_MIXER_SATURATE_EN defined) or wrap to SAMPLE_WIDTH.
`default_nettype none

module voice_sum_sat
   import voice_mixer_pkg::*;
#(
   parameter int NUM_VOICES   = 3,
   parameter int SAMPLE_WIDTH = 16,
   parameter int MIX_SHIFT    = 2
) (
   input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] samples_i,
   output logic [SAMPLE_WIDTH-1:0]            mix_o,
   output logic                               saturated_o
);

   localparam int SUM_W = SAMPLE_WIDTH + GUARD_BITS;

   logic signed [SUM_W-1:0] sum_w;
   logic signed [SUM_W-1:0] shifted_w;

   always_comb begin
      sum_w = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         sum_w = sum_w + {{GUARD_BITS{samples_i[i*SAMPLE_WIDTH + SAMPLE_WIDTH - 1]}},
                          samples_i[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]};
      end
      shifted_w = sum_w >>> MIX_SHIFT;
   end

`ifdef VOICE_MIXER_SATURATE_EN
   localparam logic signed [SUM_W-1:0] SAT_MAX = {{(GUARD_BITS+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN = {{(GUARD_BITS+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

   always_comb begin
      mix_o       = SAMPLE_WIDTH'(shifted_w);
      saturated_o = 1'b0;
      if (shifted_w > SAT_MAX) begin
         mix_o       = SAMPLE_WIDTH'(SAT_MAX);
         saturated_o = 1'b1;
      end else if (shifted_w < SAT_MIN) begin
         mix_o       = SAMPLE_WIDTH'(SAT_MIN);
         saturated_o = 1'b1;
      end
   end
`else
   assign mix_o       = SAMPLE_WIDTH'(shifted_w);
   assign saturated_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/voice_mixer.sv
// voice_mixer: requests one sample per active voice, collects them with a timeout and
// emits their scaled sum; VOICE_MIXER_SATURATE_EN selects clamping instead of wrap.
`default_nettype none

module voice_mixer
   import voice_mixer_pkg::*;
#(
   parameter int NUM_VOICES   = 3,
   parameter int SAMPLE_WIDTH = 16,
   parameter int MIX_SHIFT    = 2,
   parameter int TIMEOUT      = 255
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               generate_next_sample,
   input  logic [NUM_VOICES-1:0]              voice_active,
   input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] sample_in,
   input  logic [NUM_VOICES-1:0]              sample_ready_in,
   output logic [NUM_VOICES-1:0]              request_sample,
   output logic [SAMPLE_WIDTH-1:0]            sample_out,
   output logic                               sample_ready,
   output logic [NUM_VOICES-1:0]              missed_voices,
   output logic                               saturated,
   output logic                               overrun
);

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   state_t                            state_q,   state_d;
   logic [NUM_VOICES-1:0]             pending_q, pending_d;
   logic [NUM_VOICES*SAMPLE_WIDTH-1:0] buffer_q,  buffer_d;
   logic [CNT_WIDTH-1:0]              cnt_q,     cnt_d;
   logic [NUM_VOICES-1:0]             req_q,     req_d;
   logic [SAMPLE_WIDTH-1:0]           out_q,     out_d;
   logic                              ready_q,   ready_d;
   logic [NUM_VOICES-1:0]             missed_q,  missed_d;
   logic                              sat_q,     sat_d;
   logic                              ovr_q,     ovr_d;

   logic [SAMPLE_WIDTH-1:0]           mix_w;
   logic                              mix_sat_w;

   voice_sum_sat #(
      .NUM_VOICES   (NUM_VOICES),
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .MIX_SHIFT    (MIX_SHIFT)
   ) u_sum (
      .samples_i   (buffer_q),
      .mix_o       (mix_w),
      .saturated_o (mix_sat_w)
   );

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      buffer_d  = buffer_q;
      cnt_d     = cnt_q;
      req_d     = '0;
      out_d     = out_q;
      ready_d   = 1'b0;
      missed_d  = missed_q;
      sat_d     = sat_q;
      ovr_d     = generate_next_sample && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (generate_next_sample) begin
               pending_d = voice_active;
               buffer_d  = '0;
               cnt_d     = '0;
               req_d     = voice_active;
               state_d   = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (sample_ready_in[i] && pending_q[i]) begin
                  buffer_d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                  pending_d[i] = 1'b0;
               end
            end
            cnt_d = cnt_q + CNT_WIDTH'(1);
            // Voices still pending when we leave are reported as missed from pending_q in MIX.
            if ((pending_d == '0) || (cnt_q == TIMEOUT_LAST)) begin
               state_d = ST_MIX;
            end
         end
         ST_MIX: begin
            out_d    = mix_w;
            sat_d    = mix_sat_w;
            missed_d = pending_q;
            ready_d  = 1'b1;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         buffer_q  <= '0;
         cnt_q     <= '0;
         req_q     <= '0;
         out_q     <= '0;
         ready_q   <= 1'b0;
         missed_q  <= '0;
         sat_q     <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         buffer_q  <= buffer_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         out_q     <= out_d;
         ready_q   <= ready_d;
         missed_q  <= missed_d;
         sat_q     <= sat_d;
         ovr_q     <= ovr_d;
      end
   end

   assign request_sample = req_q;
   assign sample_out     = out_q;
   assign sample_ready   = ready_q;
   assign missed_voices  = missed_q;
   assign saturated      = sat_q;
   assign overrun        = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: two mixers (MIX_SHIFT 1 and 0, TIMEOUT 8) on shared stimulus, checked
// against a cycle-count/integer-arithmetic reference model.
`default_nettype none

module tb_voice_mixer;

   localparam int NV  = 3;
   localparam int SW  = 16;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          gen = 1'b0;
   logic [NV-1:0] act_in = '0;
   logic [NV-1:0] rdy_in = '0;
   logic [NV*SW-1:0] smp_in = '0;

   logic [NV-1:0] req_a, req_b, miss_a, miss_b;
   logic [SW-1:0] out_a, out_b;
   logic          rdy_a, rdy_b, sat_a, sat_b, ovr_a, ovr_b;

   int errors = 0;
   int checks = 0;
   int dly [NV];
   int smp [NV];
   logic [SW-1:0] prev_a = '0;
   logic [SW-1:0] prev_b = '0;

   always #5 clk = ~clk;

   voice_mixer #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .MIX_SHIFT(1), .TIMEOUT(TMO)) dut_a (
      .clk                  (clk),
      .reset                (reset),
      .generate_next_sample (gen),
      .voice_active         (act_in),
      .sample_in            (smp_in),
      .sample_ready_in      (rdy_in),
      .request_sample       (req_a),
      .sample_out           (out_a),
      .sample_ready         (rdy_a),
      .missed_voices        (miss_a),
      .saturated            (sat_a),
      .overrun              (ovr_a)
   );

   voice_mixer #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .MIX_SHIFT(0), .TIMEOUT(TMO)) dut_b (
      .clk                  (clk),
      .reset                (reset),
      .generate_next_sample (gen),
      .voice_active         (act_in),
      .sample_in            (smp_in),
      .sample_ready_in      (rdy_in),
      .request_sample       (req_b),
      .sample_out           (out_b),
      .sample_ready         (rdy_b),
      .missed_voices        (miss_b),
      .saturated            (sat_b),
      .overrun              (ovr_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns {saturated, sample} for an integer voice total.
   function automatic logic [16:0] model_mix(input int total, input int sh);
      int s;
      s = total >>> sh;
`ifdef VOICE_MIXER_SATURATE_EN
      if (s > 32767)  return {1'b1, 16'h7FFF};
      if (s < -32768) return {1'b1, 16'h8000};
`endif
      return {1'b0, s[15:0]};
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_a"}, 32'(req_a), 0);
      chk({tag, "_out_a"}, 32'(out_a), 0);
      chk({tag, "_rdy_a"}, 32'(rdy_a), 0);
      chk({tag, "_miss_a"}, 32'(miss_a), 0);
      chk({tag, "_sat_a"}, 32'(sat_a), 0);
      chk({tag, "_ovr_a"}, 32'(ovr_a), 0);
      chk({tag, "_out_b"}, 32'(out_b), 0);
      chk({tag, "_rdy_b"}, 32'(rdy_b), 0);
   endtask

   // One request; dly[i] is the cycle offset after request_sample at which voice i strobes (-1: never).
   task automatic run_mix(input logic [NV-1:0] act, input int ovr_at);
      int          end_c;
      int          total;
      int          ready_t;
      bit          all_in;
      logic [NV-1:0] miss_e;
      logic [16:0] ra;
      logic [16:0] rb;
      end_c  = 1;
      all_in = 1'b1;
      total  = 0;
      miss_e = '0;
      for (int i = 0; i < NV; i++) begin
         if (act[i]) begin
            if (dly[i] < 0 || dly[i] + 1 > TMO) all_in = 1'b0;
            else if (dly[i] + 1 > end_c) end_c = dly[i] + 1;
         end
      end
      if (!all_in) end_c = TMO;
      for (int i = 0; i < NV; i++) begin
         if (act[i]) begin
            if (dly[i] >= 0 && dly[i] + 1 <= end_c) total += smp[i];
            else miss_e[i] = 1'b1;
         end
      end
      ready_t = end_c + 2;
      ra = model_mix(total, 1);
      rb = model_mix(total, 0);

      gen    = 1'b1;
      act_in = act;
      step();
      gen = 1'b0;
      for (int t = 1; t <= ready_t + 2; t++) begin
         chk("req_a", 32'(req_a), (t == 1) ? 32'(act) : 32'd0);
         chk("req_b", 32'(req_b), (t == 1) ? 32'(act) : 32'd0);
         chk("ready_a", 32'(rdy_a), 32'(t == ready_t));
         chk("ready_b", 32'(rdy_b), 32'(t == ready_t));
         chk("overrun_a", 32'(ovr_a), 32'(ovr_at > 0 && t == ovr_at + 1));
         chk("out_a", 32'(out_a), (t >= ready_t) ? 32'(ra[15:0]) : 32'(prev_a));
         chk("out_b", 32'(out_b), (t >= ready_t) ? 32'(rb[15:0]) : 32'(prev_b));
         if (t == ready_t) begin
            chk("missed_a", 32'(miss_a), 32'(miss_e));
            chk("missed_b", 32'(miss_b), 32'(miss_e));
            chk("sat_a", 32'(sat_a), 32'(ra[16]));
            chk("sat_b", 32'(sat_b), 32'(rb[16]));
         end
         gen = (t == ovr_at);
         for (int i = 0; i < NV; i++) begin
            rdy_in[i] = (dly[i] >= 0) && (t == dly[i] + 1);
            smp_in[i*SW +: SW] = rdy_in[i] ? 16'(smp[i]) : 16'($urandom);
         end
         step();
      end
      rdy_in = '0;
      gen    = 1'b0;
      prev_a = ra[15:0];
      prev_b = rb[15:0];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      repeat (3) step();
      chk_all_zero("reset");
      reset = 1'b0;
      step();

      // Simultaneous strobes: 1000 + 2000 - 500
      dly = '{0, 0, 0};
      smp = '{1000, 2000, -500};
      run_mix(3'b111, 0);

      // Full-scale inputs overflow the output range
      dly = '{0, 1, 2};
      smp = '{32767, 32767, 32767};
      run_mix(3'b111, 0);

      // Voice 2 never answers: timeout path
      dly = '{0, 2, -1};
      smp = '{400, 400, 1234};
      run_mix(3'b111, 0);

      // No active voices
      dly = '{0, 1, 2};
      smp = '{111, 222, 333};
      run_mix(3'b000, 0);

      // Second request while collecting
      dly = '{1, 3, 0};
      smp = '{-700, 300, 5000};
      run_mix(3'b011, 2);

      // Reset in the middle of collection
      dly    = '{0, 0, 0};
      act_in = 3'b111;
      gen    = 1'b1;
      step();
      gen    = 1'b0;
      rdy_in = 3'b001;
      smp_in = {16'd0, 16'd0, 16'd1234};
      step();
      rdy_in = '0;
      reset  = 1'b1;
      step();
      chk_all_zero("abort");
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         chk("abort_no_ready_a", 32'(rdy_a), 0);
         chk("abort_no_ready_b", 32'(rdy_b), 0);
         step();
      end
      prev_a = '0;
      prev_b = '0;
      smp = '{-20, -30, 7};
      dly = '{2, 0, 1};
      run_mix(3'b111, 0);

      for (int n = 0; n < 40; n++) begin
         logic [NV-1:0] act_r;
         int            ovr_r;
         act_r = NV'($urandom_range(0, 7));
         for (int i = 0; i < NV; i++) begin
            dly[i] = int'($urandom_range(0, 10)) - 1;
            smp[i] = int'($signed(16'($urandom)));
         end
         ovr_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_mix(act_r, ovr_r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
